pc_flags_unit: RTL
==================

// Module: pc_flags_unit
// PURPOSE
//  Architectural state stage of the single-cycle LEGv8 core: holds the PC and NZCV flag registers.
//  Downstream of the control unit: consumes pc_src and set_flags, and selects the next PC.
//  Upstream of the control unit: returns eq/ne/ge/lt/gt/le, decoded from the registered flags, for B.cond.
//  Also keeps a retired-instruction counter for bring-up and debug.
// PARAMETERS
//  XLEN      64   datapath/PC width
//  RESET_PC  0    PC value loaded on reset (must be a multiple of 4)
//  CNT_W     32   width of retired-instruction counter
// PORTS
//  clk            in   1     core clock, all state on rising edge
//  reset          in   1     synchronous, active-high; overrides every other input
//  stall          in   1     1 = hold PC, flags and counter this cycle
//  pc_src         in   2     00 PC+4, 01 PC+(offset<<2), 10 br_target, 11 reserved (treated as 00)
//  branch_offset  in   XLEN  sign-extended word offset from SEU
//  br_target      in   XLEN  register operand for BR
//  set_flags      in   1     1 = load NZCV from ALU this cycle
//  alu_n/z/c/v    in   1     ALU result flags
//  pc             out  XLEN  current PC (registered)
//  pc_plus4       out  XLEN  pc+4, combinational
//  flags          out  4     registered {N,Z,C,V}
//  eq,ne,ge,lt,gt,le out 1   condition decode of registered flags, combinational
//  retired        out  CNT_W count of non-stalled, non-reset cycles
//  align_fault    out  1     sticky misaligned-target fault (only with PC_ALIGN_CHECK_EN; tied 0 otherwise)
// BEHAVIOUR
//  - Reset (sync): pc=RESET_PC, flags=4'b0000, retired=0, align_fault=0.
//    Reset decode with flags=0 is eq=0 ne=1 ge=1 lt=0 gt=1 le=0.
//  - Each rising edge with !reset && !stall:
//      pc <= next_pc.
//      flags <= set_flags ? {alu_n,alu_z,alu_c,alu_v} : flags.
//      retired <= retired+1.
//  - When stall=1: all state holds, including when set_flags=1. Reset during stall still resets.
//  - next_pc arithmetic: pc+4 and pc+(branch_offset<<2), both modulo 2^XLEN.
//    The shift discards the top 2 bits of branch_offset. Wrap-around is silent.
//  - Latency: the PC changes one edge after pc_src is presented. The new flags are visible on eq..le
//    from the next cycle. A B.cond therefore sees the flags of the most recent earlier flag-setting
//    instruction, never the flags of the same cycle.
//  - Condition decode (from registered flags):
//      eq=Z, ne=!Z, ge=(N==V), lt=(N!=V), gt=!Z&&(N==V), le=Z||(N!=V).
//  - retired wraps from all-ones to 0.
//  - No handshake: single-cycle core, so stall is the only flow control.
// CONFIGURATION
//  - PC_ALIGN_CHECK_EN defined:
//    - If next_pc[1:0]!=0 on an advancing edge: PC holds its old value, align_fault is set, and
//      flags and retired still update.
//    - align_fault stays 1 until reset.
//    - While align_fault=1 the PC is frozen; flags and retired continue to update.
//  - PC_ALIGN_CHECK_EN undefined: no check. next_pc is always loaded; align_fault=0.
// STRUCTURE
//  - legv8_pkg:
//    - PC_SRC_SEQ/BRANCH/REG constants (2'b00/01/10).
//    - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
//  - Sub-module cond_eval: purely combinational, flags[3:0] -> eq,ne,ge,lt,gt,le.
//    The CU-side condition logic shares the same encoding.
//  - Top level: PC register, next-PC mux, flag register, retired counter, optional alignment checker.
// TESTING
//  1 Reset then 3 cycles pc_src=00 (RESET_PC=0)
//    -> pc 0,4,8,12; retired=3; flags=0; ne=ge=gt=1, eq=lt=le=0.
//  2 At pc=0x100: pc_src=01, offset=-2 (all-ones..FE) -> pc=0xF8.
//    Then pc=0xF8, pc_src=10, br_target=0x2000 -> pc=0x2000.
//  3 set_flags=1 with N=1,Z=0,C=0,V=0 -> next cycle flags=4'b1000, lt=1, le=1, ge=0, gt=0.
//    Then set_flags=0 with different alu flags -> flags unchanged.
//  4 stall=1 for 2 cycles with pc_src=01, set_flags=1 -> pc, flags, retired unchanged.
//    Assert reset during the stall -> pc=RESET_PC, flags=0, retired=0.
//  5 pc=0xFFFF_FFFF_FFFF_FFFC, pc_src=00 -> pc=0. retired preset near max wraps to 0.
//  6 With PC_ALIGN_CHECK_EN: br_target=0x1002 -> pc holds, align_fault=1 until reset.
//    Without the macro -> pc=0x1002, align_fault=0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encodings: next-PC source select and NZCV bit positions.
// Used by the PC/flags stage and by the control unit's condition logic.
package legv8_pkg;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'b00,
      PC_SRC_BRANCH = 2'b01,
      PC_SRC_REG    = 2'b10,
      PC_SRC_RSVD   = 2'b11
   } pc_src_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/pc_flags_unit_cond_eval.sv
// cond_eval: combinational B.cond decode of a registered NZCV word.
// The carry bit plays no part in the signed/equality conditions decoded here.
module cond_eval
   import legv8_pkg::*;
(
   input  logic [3:0] flags,
   output logic       eq,
   output logic       ne,
   output logic       ge,
   output logic       lt,
   output logic       gt,
   output logic       le
);

   logic n_bit;
   logic z_bit;
   logic v_bit;

   // Decode equality and signed-compare conditions from N, Z and V.
   always_comb begin
      n_bit = flags[FLAG_N];
      z_bit = flags[FLAG_Z];
      v_bit = flags[FLAG_V];
      eq    = z_bit;
      ne    = ~z_bit;
      ge    = (n_bit == v_bit);
      lt    = (n_bit != v_bit);
      gt    = ~z_bit & (n_bit == v_bit);
      le    = z_bit | (n_bit != v_bit);
   end

endmodule

// File: rtl/pc_flags_unit.sv
// pc_flags_unit: architectural PC and NZCV flag registers of the single-cycle
// LEGv8 core, next-PC select, B.cond decode and a retired-instruction counter.
// Optional feature macro: PC_ALIGN_CHECK_EN enables a sticky misaligned-target
// fault that freezes the PC; without it align_fault is tied low.
module pc_flags_unit
   import legv8_pkg::*;
#(
   parameter int               XLEN     = 64,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [1:0]       pc_src,
   input  logic [XLEN-1:0]  branch_offset,
   input  logic [XLEN-1:0]  br_target,
   input  logic             set_flags,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic [3:0]       flags,
   output logic             eq,
   output logic             ne,
   output logic             ge,
   output logic             lt,
   output logic             gt,
   output logic             le,
   output logic [CNT_W-1:0] retired,
   output logic             align_fault
);

   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] branch_pc;
   logic            pc_load;

   // Sequential and PC-relative targets; the <<2 drops the offset's top two bits
   // and all additions wrap silently modulo 2^XLEN.
   always_comb begin
      pc_plus4  = pc + XLEN'(4);
      branch_pc = pc + {branch_offset[XLEN-3:0], 2'b00};
      case (pc_src)
         PC_SRC_BRANCH: next_pc = branch_pc;
         PC_SRC_REG:    next_pc = br_target;
         default:       next_pc = pc_plus4;
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   logic misaligned;
   logic align_fault_q;

   // A misaligned target is never loaded; once faulted the PC stays frozen.
   always_comb begin
      misaligned = (next_pc[1:0] != 2'b00);
      pc_load    = ~align_fault_q & ~misaligned;
   end

   // Sticky fault, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         align_fault_q <= 1'b0;
      end else if (!stall && misaligned) begin
         align_fault_q <= 1'b1;
      end
   end

   assign align_fault = align_fault_q;
`else
   assign pc_load     = 1'b1;
   assign align_fault = 1'b0;
`endif

   // PC register: advances on every non-stalled edge unless the target is blocked.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (!stall && pc_load) begin
         pc <= next_pc;
      end
   end

   // NZCV register: loaded only on flag-setting, non-stalled cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else if (!stall && set_flags) begin
         flags <= {alu_n, alu_z, alu_c, alu_v};
      end
   end

   // Retired-instruction counter, wraps from all-ones to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= '0;
      end else if (!stall) begin
         retired <= retired + CNT_W'(1);
      end
   end

   cond_eval u_cond_eval (
      .flags (flags),
      .eq    (eq),
      .ne    (ne),
      .ge    (ge),
      .lt    (lt),
      .gt    (gt),
      .le    (le)
   );

endmodule
